alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle MIPS integer ALU.
- Adds registered outputs, signed overflow/zero flags, NOR, and a multi-cycle unsigned multiply and divide producing HI/LO results.
- Sits in the EX stage; the pipeline control stalls on `busy` and captures results on `done`.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4). Multiply/divide iteration count equals WIDTH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  operation request; sampled only when busy=0
- ALUcontrol  in  4  operation code, sampled with start
- A  in  WIDTH  operand A, sampled with start
- B  in  WIDTH  operand B, sampled with start
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse; outputs valid from this cycle
- ALUresult  out  WIDTH  primary result (LO for MULT/DIV)
- hi  out  WIDTH  upper product / remainder; 0 for non-MULT/DIV ops
- zero  out  1  ALUresult == 0 (all ops)
- overflow  out  1  signed overflow, ADD/SUB only; else 0
- div_by_zero  out  1  DIV with B==0; else 0

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, ALUresult=0, hi=0, zero=0, overflow=0, div_by_zero=0. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, DONE.
  - IDLE/DONE + start + single-cycle op -> DONE.
  - IDLE/DONE + start + MULT/DIV -> RUN with counter=WIDTH.
  - RUN: counter decrements each cycle; at counter==1 -> DONE.
  - DONE without start -> IDLE.
  - Back-to-back starts are accepted in DONE.
- start while busy=1 is ignored (operands not re-sampled).
- Latency (start at edge t):
  - single-cycle op: done=1 in cycle t+1
  - MULT/DIV: busy=1 for cycles t+1..t+WIDTH, done=1 in cycle t+WIDTH+1
  - busy=0 in DONE.
- done is high for exactly one cycle. Result/flag outputs update only on entry to DONE and hold until the next DONE.
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD (mod 2^WIDTH)
  - 0110 SUB (mod 2^WIDTH)
  - 0111 SLT signed: ALUresult = 1 if $signed(A)<$signed(B), else 0
  - 1100 NOR
  - 1000 MULT unsigned: {hi,ALUresult} = A*B (2*WIDTH bits), shift-add, one bit per cycle
  - 1001 DIV unsigned restoring: ALUresult = quotient, hi = remainder, one bit per cycle
- Other opcodes: illegal; single-cycle; ALUresult=0, hi=0, flags 0 except zero=1.
- Overflow:
  - ADD: A,B same sign and result sign differs.
  - SUB: A,B differ in sign and result sign differs from A.
- DIV with B==0: ALUresult = all ones, hi = A, div_by_zero=1. Still takes WIDTH cycles, so latency is uniform.
- Operands are latched internally at start; A/B/ALUcontrol may change while busy without effect.

Optional Feature:
- Macro `ALU_SEQ_SIGNED_MULDIV_EN`.
- Defined: opcodes 1010 MULTS and 1011 DIVS are enabled, with the same latency as the unsigned versions.
  - Operands are converted to magnitude, run through the unsigned datapath, then the result is negated as needed.
  - Quotient sign = sign(A) xor sign(B); remainder takes the sign of A.
  - DIVS by zero behaves as DIV by zero.
- Undefined: 1010/1011 are illegal opcodes (single-cycle, result 0, zero=1).

Test Plan:
- Reset: assert rst for 2 cycles, including mid-MULT -> all outputs 0, busy=0, no done pulse afterwards.
- ADD A=0x7FFFFFFF, B=0x00000001 -> done at t+1; ALUresult=0x80000000, overflow=1, zero=0. SUB A=5, B=5 -> ALUresult=0, zero=1, overflow=0.
- SLT A=0xFFFFFFFF, B=0x00000001 -> ALUresult=1. NOR A=0, B=0x0000FFFF -> ALUresult=0xFFFF0000.
- MULT A=B=0xFFFFFFFF -> busy for 32 cycles, done at t+33; hi=0xFFFFFFFE, ALUresult=0x00000001. MULT 7*6 -> hi=0, ALUresult=42.
- DIV A=100, B=7 -> ALUresult=14, hi=2, done at t+33. DIV A=9, B=0 -> ALUresult=0xFFFFFFFF, hi=9, div_by_zero=1.
- Pulse start with ADD while a MULT is busy -> ignored, MULT result unchanged. Issue a new start in the DONE cycle -> accepted; next done arrives one cycle later.
- With the macro defined: DIVS A=-7, B=2 -> ALUresult=-3, hi=-1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked EX-stage ALU: registered single-cycle logic ops plus WIDTH-cycle shift-add multiply
// and restoring divide. Define ALU_SEQ_SIGNED_MULDIV_EN to enable the signed MULTS/DIVS opcodes.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALUcontrol,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUresult,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
`ifdef ALU_SEQ_SIGNED_MULDIV_EN
    localparam logic [3:0] OP_MULTS = 4'b1010;
    localparam logic [3:0] OP_DIVS  = 4'b1011;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               dbz_q, dbz_d;

    logic               mul_op, div_op, sgn_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   add_res, sub_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff, div_hi_nx, div_lo_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

`ifdef ALU_SEQ_SIGNED_MULDIV_EN
    assign sgn_op = (ALUcontrol == OP_MULTS) || (ALUcontrol == OP_DIVS);
    assign mul_op = (ALUcontrol == OP_MULT) || (ALUcontrol == OP_MULTS);
    assign div_op = (ALUcontrol == OP_DIV) || (ALUcontrol == OP_DIVS);
`else
    assign sgn_op = 1'b0;
    assign mul_op = (ALUcontrol == OP_MULT);
    assign div_op = (ALUcontrol == OP_DIV);
`endif

    // Signed ops run on magnitudes; the sign fix-up is applied when the last iteration completes
    assign a_neg = sgn_op & A[WIDTH-1];
    assign b_neg = sgn_op & B[WIDTH-1];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    assign add_res = A + B;
    assign sub_res = A - B;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_div_d   = is_div_q;
        neg_lo_d   = neg_lo_q;
        neg_hi_d   = neg_hi_q;
        dbz_pend_d = dbz_pend_q;
        a_raw_d    = a_raw_q;
        opnd_d     = opnd_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        res_d      = res_q;
        hi_d       = hi_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        dbz_d      = dbz_q;

        // Multiply: {acc_hi, acc_lo} holds the partial product with the multiplier shifting out of acc_lo
        mul_sum   = {1'b0, acc_hi_q} + {1'b0, opnd_q & {WIDTH{acc_lo_q[0]}}};
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in
        rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (rem_sh >= {1'b0, opnd_q});
        div_diff  = rem_sh[WIDTH-1:0] - opnd_q;
        div_hi_nx = div_ge ? div_diff : rem_sh[WIDTH-1:0];
        div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ge};

        prod = {mul_hi_nx, mul_lo_nx};
        if (neg_lo_q) begin
            prod = -prod;
        end
        quo = neg_lo_q ? -div_lo_nx : div_lo_nx;
        rem = neg_hi_q ? -div_hi_nx : div_hi_nx;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_div_q) begin
                    acc_hi_d = div_hi_nx;
                    acc_lo_d = div_lo_nx;
                end else begin
                    acc_hi_d = mul_hi_nx;
                    acc_lo_d = mul_lo_nx;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    ovf_d   = 1'b0;
                    dbz_d   = 1'b0;
                    if (!is_div_q) begin
                        res_d = prod[WIDTH-1:0];
                        hi_d  = prod[2*WIDTH-1:WIDTH];
                    end else if (dbz_pend_q) begin
                        res_d = '1;
                        hi_d  = a_raw_q;
                        dbz_d = 1'b1;
                    end else begin
                        res_d = quo;
                        hi_d  = rem;
                    end
                    zero_d = (res_d == '0);
                end
            end
            default: begin
                if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
                if (start) begin
                    if (mul_op || div_op) begin
                        state_d    = S_RUN;
                        cnt_d      = CW'(WIDTH);
                        is_div_d   = div_op;
                        neg_lo_d   = a_neg ^ b_neg;
                        neg_hi_d   = a_neg;
                        dbz_pend_d = div_op && (B == '0);
                        a_raw_d    = A;
                        opnd_d     = mul_op ? a_mag : b_mag;
                        acc_hi_d   = '0;
                        acc_lo_d   = mul_op ? b_mag : a_mag;
                    end else begin
                        state_d = S_DONE;
                        res_d   = '0;
                        hi_d    = '0;
                        ovf_d   = 1'b0;
                        dbz_d   = 1'b0;
                        case (ALUcontrol)
                            OP_AND: res_d = A & B;
                            OP_OR:  res_d = A | B;
                            OP_NOR: res_d = ~(A | B);
                            OP_ADD: begin
                                res_d = add_res;
                                ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
                            end
                            OP_SUB: begin
                                res_d = sub_res;
                                ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
                            end
                            OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
                            default: res_d = '0;
                        endcase
                        zero_d = (res_d == '0);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_lo_q   <= 1'b0;
            neg_hi_q   <= 1'b0;
            dbz_pend_q <= 1'b0;
            a_raw_q    <= '0;
            opnd_q     <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            res_q      <= '0;
            hi_q       <= '0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_div_q   <= is_div_d;
            neg_lo_q   <= neg_lo_d;
            neg_hi_q   <= neg_hi_d;
            dbz_pend_q <= dbz_pend_d;
            a_raw_q    <= a_raw_d;
            opnd_q     <= opnd_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            res_q      <= res_d;
            hi_q       <= hi_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign ALUresult   = res_q;
    assign hi          = hi_q;
    assign zero        = zero_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule
